if_fetch: RTL

Instruction-fetch initiator that drives the synchronous-read instruction memory port (imaddr/imce/imwe/imdin) and consumes the returned inst.
- Holds the PC and issues one fetch per cycle.
- Tags each returned instruction with its PC and a valid bit for the ID stage.
- Handles hazard stalls, branch/jump redirects and misaligned-target faults.
- Provides a handshaked boot-loader path that writes program words into instruction memory and then restarts fetch.

---
 rtl/if_fetch.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/if_fetch.sv
// Instruction-fetch initiator: owns the PC and drives the synchronous-read instruction memory port.
// Also arbitrates a handshaked boot-loader path that writes program words and then restarts fetch.
module if_fetch #(
    parameter int unsigned IM_AW    = 13,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic             cpu_clk_50M,
    input  logic             cpu_rst,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    output logic [IM_AW-1:0] imaddr,
    output logic             imce,
    output logic             imwe,
    output logic [31:0]      imdin,
    input  logic [31:0]      inst,
    output logic [31:0]      id_inst,
    output logic [31:0]      id_pc,
    output logic             id_valid,
    output logic             fetch_err,
    output logic [31:0]      fetch_badaddr,
    input  logic             ld_req,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [31:0]      ld_addr,
    input  logic [31:0]      ld_data,
    input  logic             ld_last,
    output logic [15:0]      ld_count
);

    localparam logic [1:0] S_BOOT = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_LOAD = 2'd2;
    localparam logic [1:0] S_HALT = 2'd3;

    localparam logic [15:0] LD_COUNT_MAX = 16'hFFFF;

    logic [1:0]  state, state_nx;
    logic [31:0] pc, pc_nx;
    logic [31:0] id_pc_nx;
    logic        id_valid_nx;
    logic        fetch_err_nx;
    logic [31:0] fetch_badaddr_nx;
    logic [15:0] ld_count_nx;

    // Only the word-index bits of the loader address reach the memory; the rest alias.
    logic unused_ld_addr;
    assign unused_ld_addr = ^{ld_addr[31:IM_AW+2], ld_addr[1:0]};

    // The memory holds inst while imce is low, so ID can see it directly.
    assign id_inst = inst;

    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            state <= S_BOOT;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            pc            <= RESET_PC;
            id_pc         <= RESET_PC;
            id_valid      <= 1'b0;
            fetch_err     <= 1'b0;
            fetch_badaddr <= 32'h0000_0000;
            ld_count      <= 16'h0000;
        end else begin
            pc            <= pc_nx;
            id_pc         <= id_pc_nx;
            id_valid      <= id_valid_nx;
            fetch_err     <= fetch_err_nx;
            fetch_badaddr <= fetch_badaddr_nx;
            ld_count      <= ld_count_nx;
        end
    end

    // Next-state, next-register and memory-port decode; port strobes are forced low during reset.
    always_comb begin
        state_nx         = state;
        pc_nx            = pc;
        id_pc_nx         = id_pc;
        id_valid_nx      = id_valid;
        fetch_err_nx     = fetch_err;
        fetch_badaddr_nx = fetch_badaddr;
        ld_count_nx      = ld_count;
        imce             = 1'b0;
        imwe             = 1'b0;
        imaddr           = pc[IM_AW+1:2];
        imdin            = 32'h0000_0000;
        ld_ready         = 1'b0;

        if (!cpu_rst) begin
            case (state)
                S_BOOT: begin
                    imce        = 1'b1;
                    imaddr      = RESET_PC[IM_AW+1:2];
                    id_pc_nx    = RESET_PC;
                    id_valid_nx = 1'b1;
                    pc_nx       = RESET_PC + 32'd4;
                    state_nx    = S_RUN;
                end

                S_RUN: begin
                    if (ld_req) begin
                        id_valid_nx = 1'b0;
                        ld_count_nx = 16'h0000;
                        state_nx    = S_LOAD;
                    end else if (redirect_valid && (redirect_pc[1:0] == 2'b00)) begin
                        // An aligned redirect overrides a hazard stall.
                        imce        = 1'b1;
                        imaddr      = redirect_pc[IM_AW+1:2];
                        id_pc_nx    = redirect_pc;
                        id_valid_nx = 1'b1;
                        pc_nx       = redirect_pc + 32'd4;
                    end else if (redirect_valid) begin
                        id_valid_nx      = 1'b0;
                        fetch_err_nx     = 1'b1;
                        fetch_badaddr_nx = redirect_pc;
                        state_nx         = S_HALT;
                    end else if (!stall) begin
                        imce        = 1'b1;
                        imaddr      = pc[IM_AW+1:2];
                        id_pc_nx    = pc;
                        id_valid_nx = 1'b1;
                        pc_nx       = pc + 32'd4;
                    end
                end

                S_LOAD: begin
                    ld_ready    = 1'b1;
                    id_valid_nx = 1'b0;
                    if (ld_valid) begin
                        imce   = 1'b1;
                        imwe   = 1'b1;
                        imaddr = ld_addr[IM_AW+1:2];
                        imdin  = ld_data;
                        if (ld_count != LD_COUNT_MAX) begin
                            ld_count_nx = ld_count + 16'd1;
                        end
                        if (ld_last) begin
                            pc_nx    = RESET_PC;
                            state_nx = S_BOOT;
                        end
                    end
                end

                S_HALT: begin
                    id_valid_nx = 1'b0;
                end

                default: begin
                    state_nx = S_HALT;
                end
            endcase
        end
    end

endmodule
